// File: rtl/actor_port_pkg.sv
// Shared constants and helpers for actor port FIFOs.
package actor_port_pkg;

    // Width of the COUNT field on actor ports.
    localparam int unsigned COUNT_W = 16;

    // Default token data width.
    localparam int unsigned TOKEN_W = 8;

    // Ceiling log2, used to derive pointer widths from queue depth.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/actor_port_fifo_mem.sv
// Token storage: register file with synchronous write and asynchronous read.
// Kept separate so it can be swapped for distributed RAM.
module actor_port_fifo_mem #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/actor_port_fifo.sv
// First-word-fall-through token queue between an actor output port and the
// next actor's input port, with a sticky protocol-error flag.
module actor_port_fifo
    import actor_port_pkg::*;
#(
    parameter int unsigned WIDTH  = TOKEN_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [WIDTH-1:0]   In_DATA,
    input  logic               In_SEND,
    input  logic [COUNT_W-1:0] In_COUNT,
    output logic               In_RDY,
    output logic               In_ACK,
    output logic [WIDTH-1:0]   Out_DATA,
    output logic               Out_SEND,
    output logic [COUNT_W-1:0] Out_COUNT,
    input  logic               Out_ACK,
    output logic               ERR
);

    localparam logic [ADDR_W:0] OCC_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] OCC_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic              rdy_q;
    logic              err_q, err_d;
    logic              full, empty, push, pop;

    assign full  = (occ_q == OCC_FULL);
    assign empty = (occ_q == '0);

    // Reset gates the ack so a token is never acknowledged and then discarded.
    assign push = In_SEND & ~full & ~RESET;
    assign pop  = Out_ACK & ~empty;

    // Next-state occupancy and sticky error detection.
    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
        err_d = err_q
              | (In_SEND & full)
              | (Out_ACK & empty)
              | (In_SEND & (In_COUNT != COUNT_W'(1)));
    end

    // Pointer, occupancy, ready and error registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            occ_q <= occ_d;
            rdy_q <= ~(occ_d == OCC_FULL);
            err_q <= err_d;
        end
    end

    actor_port_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (In_DATA),
        .raddr (rd_ptr_q),
        .rdata (Out_DATA)
    );

    assign In_RDY    = rdy_q;
    assign In_ACK    = push;
    assign Out_SEND  = ~empty;
    assign Out_COUNT = COUNT_W'(occ_q);
    assign ERR       = err_q;

endmodule

// File: tb/tb_actor_port_fifo.sv
// Directed self-checking bench for actor_port_fifo (WIDTH 8, DEPTH 16).
module tb_actor_port_fifo;

    logic        CLK;
    logic        RESET;
    logic [7:0]  In_DATA;
    logic        In_SEND;
    logic [15:0] In_COUNT;
    logic        In_RDY;
    logic        In_ACK;
    logic [7:0]  Out_DATA;
    logic        Out_SEND;
    logic [15:0] Out_COUNT;
    logic        Out_ACK;
    logic        ERR;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] exp_q [$];
    logic [7:0] d;

    actor_port_fifo #(
        .WIDTH  (8),
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .In_DATA   (In_DATA),
        .In_SEND   (In_SEND),
        .In_COUNT  (In_COUNT),
        .In_RDY    (In_RDY),
        .In_ACK    (In_ACK),
        .Out_DATA  (Out_DATA),
        .Out_SEND  (Out_SEND),
        .Out_COUNT (Out_COUNT),
        .Out_ACK   (Out_ACK),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        In_SEND  = 1'b0;
        Out_ACK  = 1'b0;
        In_COUNT = 16'd1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    // Push n consecutive values starting at first; ends at the negedge after the last drive.
    task automatic push_seq(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            In_SEND = 1'b1;
            In_DATA = 8'(first + k);
            @(negedge CLK);
            check_eq("fill_ack", In_ACK, 1);
            if (k == 15) check_eq("rdy_before_last", In_RDY, 1);
        end
    endtask

    // Pop n tokens expecting first, first+1, ...; ends at the negedge of the last pop.
    task automatic drain(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1 Out_ACK = 1'b1;
            @(negedge CLK);
            check_eq("drain_data", Out_DATA, 32'(8'(first + k)));
        end
    endtask

    initial begin
        RESET    = 1'b1;
        In_DATA  = 8'hFF;
        In_SEND  = 1'b1;
        In_COUNT = 16'd1;
        Out_ACK  = 1'b0;

        // 1. Reset and release
        @(negedge CLK);
        check_eq("rst_rdy", In_RDY, 0);
        check_eq("rst_ack", In_ACK, 0);
        check_eq("rst_send", Out_SEND, 0);
        check_eq("rst_count", Out_COUNT, 0);
        check_eq("rst_err", ERR, 0);
        In_SEND = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_eq("rdy_before_edge", In_RDY, 0);
        @(negedge CLK);
        check_eq("rdy_after_release", In_RDY, 1);

        // 2. Single token
        @(posedge CLK);
        #1;
        In_SEND = 1'b1;
        In_DATA = 8'hA5;
        @(negedge CLK);
        check_eq("single_ack", In_ACK, 1);
        check_eq("no_bypass", Out_SEND, 0);
        @(posedge CLK);
        #1 In_SEND = 1'b0;
        @(negedge CLK);
        check_eq("single_send", Out_SEND, 1);
        check_eq("single_data", Out_DATA, 8'hA5);
        check_eq("single_count", Out_COUNT, 1);
        @(posedge CLK);
        #1 Out_ACK = 1'b1;
        @(posedge CLK);
        #1 Out_ACK = 1'b0;
        @(negedge CLK);
        check_eq("single_pop_send", Out_SEND, 0);
        check_eq("single_pop_count", Out_COUNT, 0);
        check_eq("single_err", ERR, 0);

        // 3. Fill and wrap
        push_seq(0, 16);
        @(posedge CLK);
        #1 In_SEND = 1'b0;
        @(negedge CLK);
        check_eq("full_rdy", In_RDY, 0);
        check_eq("full_count", Out_COUNT, 16);
        drain(0, 8);
        @(posedge CLK);
        #1 Out_ACK = 1'b0;
        push_seq(16, 8);

        // 4. Full with simultaneous push and pop
        @(posedge CLK);
        #1;
        In_SEND = 1'b1;
        In_DATA = 8'hEE;
        Out_ACK = 1'b1;
        @(negedge CLK);
        check_eq("coll_count_before", Out_COUNT, 16);
        check_eq("coll_ack", In_ACK, 0);
        check_eq("coll_head", Out_DATA, 8'h08);
        check_eq("coll_err_before", ERR, 0);
        @(posedge CLK);
        #1;
        In_SEND = 1'b0;
        Out_ACK = 1'b0;
        @(negedge CLK);
        check_eq("coll_count", Out_COUNT, 15);
        check_eq("coll_rdy", In_RDY, 1);
        check_eq("coll_err", ERR, 1);
        drain(9, 15);
        @(posedge CLK);
        #1 Out_ACK = 1'b0;
        @(negedge CLK);
        check_eq("wrap_empty", Out_SEND, 0);
        check_eq("wrap_count", Out_COUNT, 0);

        // 5. Steady streaming at occupancy 1
        do_reset();
        @(negedge CLK);
        check_eq("rst2_err", ERR, 0);
        @(posedge CLK);
        #1;
        In_SEND = 1'b1;
        In_DATA = 8'h55;
        exp_q.push_back(8'h55);
        @(posedge CLK);
        #1;
        for (int k = 0; k < 100; k++) begin
            d = 8'($urandom_range(0, 255));
            In_DATA = d;
            In_SEND = 1'b1;
            Out_ACK = 1'b1;
            @(negedge CLK);
            check_eq("stream_data", Out_DATA, exp_q[0]);
            check_eq("stream_count", Out_COUNT, 1);
            check_eq("stream_ack", In_ACK, 1);
            void'(exp_q.pop_front());
            exp_q.push_back(d);
            @(posedge CLK);
            #1;
        end
        In_SEND = 1'b0;
        Out_ACK = 1'b0;
        @(negedge CLK);
        check_eq("stream_err", ERR, 0);
        check_eq("stream_end_count", Out_COUNT, 1);
        check_eq("stream_end_data", Out_DATA, exp_q[0]);

        // 6a. Bad COUNT still queues the token
        @(posedge CLK);
        #1;
        In_SEND  = 1'b1;
        In_COUNT = 16'd2;
        In_DATA  = 8'h3C;
        @(negedge CLK);
        check_eq("cnt2_ack", In_ACK, 1);
        check_eq("cnt2_err_before", ERR, 0);
        @(posedge CLK);
        #1;
        In_SEND  = 1'b0;
        In_COUNT = 16'd1;
        @(negedge CLK);
        check_eq("cnt2_err", ERR, 1);
        check_eq("cnt2_count", Out_COUNT, 2);
        @(posedge CLK);
        #1 Out_ACK = 1'b1;
        @(negedge CLK);
        check_eq("cnt2_head", Out_DATA, exp_q[0]);
        @(negedge CLK);
        check_eq("cnt2_token", Out_DATA, 8'h3C);
        @(posedge CLK);
        #1 Out_ACK = 1'b0;
        @(negedge CLK);
        check_eq("cnt2_drained", Out_COUNT, 0);

        // 6b. Ack while empty
        do_reset();
        @(negedge CLK);
        check_eq("rst3_err", ERR, 0);
        check_eq("rst3_count", Out_COUNT, 0);
        @(posedge CLK);
        #1 Out_ACK = 1'b1;
        @(posedge CLK);
        #1 Out_ACK = 1'b0;
        @(negedge CLK);
        check_eq("empty_ack_err", ERR, 1);
        check_eq("empty_ack_count", Out_COUNT, 0);
        check_eq("empty_ack_send", Out_SEND, 0);

        // 6c. Mid-operation reset discards tokens and clears ERR
        @(posedge CLK);
        #1;
        In_SEND = 1'b1;
        In_DATA = 8'h11;
        @(posedge CLK);
        #1 In_SEND = 1'b0;
        @(negedge CLK);
        check_eq("pre_rst_count", Out_COUNT, 1);
        RESET = 1'b1;
        #1;
        check_eq("mid_rst_send", Out_SEND, 0);
        check_eq("mid_rst_count", Out_COUNT, 0);
        check_eq("mid_rst_err", ERR, 0);
        check_eq("mid_rst_rdy", In_RDY, 0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
